// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the 8080-style LCD write path.
//   lcd_state_t  - writer FSM states (the reset-sequence states are only
//                  reachable when LCD_RESET_SEQ_EN is defined)
//   DC_CMD/DC_DATA - levels of the data/command select line
//   DEF_*        - default bus width and timing values
//   cnt_width()  - width of the shared state timer, sized so it can hold
//                  the largest (timing value - 1) it is ever loaded with
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_RST_LOW,
    ST_RST_WAIT,
    ST_IDLE,
    ST_SETUP,
    ST_WR_LOW,
    ST_WR_HIGH
  } lcd_state_t;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  localparam int DEF_DATA_W       = 16;
  localparam int DEF_T_SETUP      = 1;
  localparam int DEF_T_WRL        = 2;
  localparam int DEF_T_WRH        = 2;
  localparam int DEF_RST_LOW_CYC  = 500;
  localparam int DEF_RST_WAIT_CYC = 6000000;

  // The timer is loaded with (cycles - 1), so it needs $clog2(max) bits;
  // never let the width collapse to zero.
  function automatic int cnt_width(input int a, input int b, input int c,
                                   input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// lcd_timer: loadable down-counter shared by every FSM state.
//   clk        in  system clock
//   load       in  load load_value (has priority over counting)
//   load_value in  value loaded; a state lasting N cycles loads N-1
//   en         in  count down by one, saturating at zero
//   zero       out counter is zero, i.e. the current state's last cycle
// There is no reset port: the owner asserts load during its own reset.
module lcd_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  // Load wins; otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lcd_8080_writer.sv
// lcd_8080_writer: turns a valid/ready stream of 16-bit command/pixel words
// into timed 8080-style write cycles on the LCD pins.
//   clk, reset      system clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_dc  input word stream (in_dc: 0 cmd, 1 data)
//   lcd_on_en       panel/backlight enable request, mirrored on lcd_on
//   hw_reset_req    pulse: rerun the panel reset sequence
//   busy            FSM not idle
//   lcd_cs_n, lcd_dc_n, lcd_wr_n, lcd_rd_n, lcd_data, lcd_on, lcd_reset_n
//                   registered panel pins
// Optional feature macro: LCD_RESET_SEQ_EN enables the panel hardware reset
// sequence (RST_LOW/RST_WAIT states and hw_reset_req). Without it the FSM
// starts in IDLE, lcd_reset_n stays high and hw_reset_req is ignored.
module lcd_8080_writer
  import lcd_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int T_SETUP      = DEF_T_SETUP,
  parameter int T_WRL        = DEF_T_WRL,
  parameter int T_WRH        = DEF_T_WRH,
  parameter int RST_LOW_CYC  = DEF_RST_LOW_CYC,
  parameter int RST_WAIT_CYC = DEF_RST_WAIT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_dc,
  input  logic              lcd_on_en,
  input  logic              hw_reset_req,
  output logic              busy,
  output logic              lcd_cs_n,
  output logic              lcd_dc_n,
  output logic              lcd_wr_n,
  output logic              lcd_rd_n,
  output logic [DATA_W-1:0] lcd_data,
  output logic              lcd_on,
  output logic              lcd_reset_n
);

  localparam int CNT_W = cnt_width(T_SETUP, T_WRL, T_WRH, RST_LOW_CYC, RST_WAIT_CYC);

  localparam logic [CNT_W-1:0] LD_SETUP    = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_WRL      = CNT_W'(T_WRL - 1);
  localparam logic [CNT_W-1:0] LD_WRH      = CNT_W'(T_WRH - 1);
  localparam logic [CNT_W-1:0] LD_RST_LOW  = CNT_W'(RST_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] LD_RST_WAIT = CNT_W'(RST_WAIT_CYC - 1);

`ifdef LCD_RESET_SEQ_EN
  localparam lcd_state_t       RESET_STATE = ST_RST_LOW;
  localparam logic [CNT_W-1:0] RESET_LOAD  = LD_RST_LOW;
  localparam logic             RESET_RSTN  = 1'b0;
`else
  localparam lcd_state_t       RESET_STATE = ST_IDLE;
  localparam logic [CNT_W-1:0] RESET_LOAD  = '0;
  localparam logic             RESET_RSTN  = 1'b1;
`endif

  lcd_state_t       state;
  lcd_state_t       next_state;
  logic             step_load;
  logic [CNT_W-1:0] step_value;
  logic             accept;
  logic             enter_rst;
  logic             last;
  logic             pending;

  // The timer is reloaded on every state change and on reset, so its zero
  // flag always marks the last cycle of the current state.
  lcd_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk       (clk),
    .load      (step_load | reset),
    .load_value(reset ? RESET_LOAD : step_value),
    .en        (1'b1),
    .zero      (last)
  );

`ifdef LCD_RESET_SEQ_EN
  // A reset request is remembered until the FSM can honour it at a word
  // boundary; a fresh request beats the clear so none is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (hw_reset_req) begin
      pending <= 1'b1;
    end else if (enter_rst) begin
      pending <= 1'b0;
    end
  end
`else
  logic unused_hw_reset_req;
  assign unused_hw_reset_req = hw_reset_req;
  assign pending = 1'b0;
`endif

  // Words are taken in IDLE or in the last WR_HIGH cycle (back-to-back),
  // never while a panel reset is waiting to start.
  assign in_ready = ~pending & ((state == ST_IDLE) | ((state == ST_WR_HIGH) & last));

  // Next-state logic; each transition also reloads the timer for the new state.
  always_comb begin
    next_state = state;
    step_load  = 1'b0;
    step_value = '0;
    accept     = 1'b0;
    enter_rst  = 1'b0;
    case (state)
      ST_RST_LOW: begin
        if (last) begin
          next_state = ST_RST_WAIT;
          step_load  = 1'b1;
          step_value = LD_RST_WAIT;
        end
      end
      ST_RST_WAIT: begin
        if (last) next_state = ST_IDLE;
      end
      ST_IDLE, ST_WR_HIGH: begin
        if ((state == ST_IDLE) || last) begin
          if (pending) begin
            next_state = ST_RST_LOW;
            step_load  = 1'b1;
            step_value = LD_RST_LOW;
            enter_rst  = 1'b1;
          end else if (in_valid) begin
            next_state = ST_SETUP;
            step_load  = 1'b1;
            step_value = LD_SETUP;
            accept     = 1'b1;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      ST_SETUP: begin
        if (last) begin
          next_state = ST_WR_LOW;
          step_load  = 1'b1;
          step_value = LD_WRL;
        end
      end
      ST_WR_LOW: begin
        if (last) begin
          next_state = ST_WR_HIGH;
          step_load  = 1'b1;
          step_value = LD_WRH;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State and pin registers. Pins are derived from the next state so they
  // change on the same edge as the state they belong to; data/dc only move
  // when a word is accepted, i.e. on entry to SETUP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RESET_STATE;
      lcd_cs_n    <= 1'b1;
      lcd_wr_n    <= 1'b1;
      lcd_rd_n    <= 1'b1;
      lcd_dc_n    <= 1'b1;
      lcd_data    <= '0;
      lcd_on      <= 1'b0;
      busy        <= 1'b0;
      lcd_reset_n <= RESET_RSTN;
    end else begin
      state       <= next_state;
      lcd_cs_n    <= ~((next_state == ST_SETUP) | (next_state == ST_WR_LOW) |
                       (next_state == ST_WR_HIGH));
      lcd_wr_n    <= (next_state != ST_WR_LOW);
      lcd_rd_n    <= 1'b1;
      busy        <= (next_state != ST_IDLE);
      lcd_on      <= lcd_on_en;
      lcd_reset_n <= (next_state != ST_RST_LOW);
      if (accept) begin
        lcd_data <= in_data;
        lcd_dc_n <= in_dc;
      end
    end
  end

endmodule
